history_replayer: RTL and testbench



---
 rtl/history_replayer_pkg.sv | 12 +
 rtl/history_replayer_histram.sv | 24 ++
 rtl/history_replayer.sv | 111 +++++++++++
 tb/tb_history_replayer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/history_replayer_pkg.sv
// Shared constants and FSM encoding for the keystroke history replayer.
package history_replayer_pkg;
    localparam int HISTRAM_ADDR_WIDTH = 8;
    localparam int HISTRAM_DATA_WIDTH = 9;

    typedef enum logic [1:0] {
        HREPLAY_IDLE = 2'd0,
        HREPLAY_LOAD = 2'd1,
        HREPLAY_RD   = 2'd2,
        HREPLAY_OUT  = 2'd3
    } hr_state_e;
endpackage

// File: rtl/history_replayer_histram.sv
// Single-port history RAM with registered (1-cycle) read data.
module history_replayer_histram
    import history_replayer_pkg::*;
#(
    parameter int ADDR_WIDTH = HISTRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = HISTRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wd,
    output logic [DATA_WIDTH-1:0] o_rd
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wd;
        end
        o_rd <= r_mem[i_addr];
    end
endmodule

// File: rtl/history_replayer.sv
// Records keystrokes at the indexer's write index and replays them oldest-first.
module history_replayer
    import history_replayer_pkg::*;
#(
    parameter int ADDR_WIDTH = HISTRAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_sclr,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic                  i_type,
    input  logic [7:0]            i_asciiex,
    input  logic                  i_replay,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic                  o_type,
    output logic [7:0]            o_asciiex,
    output logic                  o_busy,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_drop
);
    hr_state_e r_state;
    hr_state_e w_next;

    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_valid;
    logic                  r_drop;

    logic                  w_we;
    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [8:0]            w_rd;

    assign w_we   = (r_state == HREPLAY_IDLE) & i_wen & ~i_sclr;
    assign w_hs   = (r_state == HREPLAY_OUT) & r_valid & i_ready;
    assign w_addr = (r_state == HREPLAY_IDLE) ? i_waddr : r_rd_ptr;

    history_replayer_histram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (9)
    ) u_histram (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (w_addr),
        .i_wd   ({i_type, i_asciiex}),
        .o_rd   (w_rd)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            HREPLAY_IDLE: if (i_replay) w_next = HREPLAY_LOAD;
            HREPLAY_LOAD: begin
                w_next = (r_count == '0) ? HREPLAY_IDLE : HREPLAY_RD;
            end
            HREPLAY_RD:   w_next = HREPLAY_OUT;
            HREPLAY_OUT: begin
                if (w_hs) begin
                    w_next = (r_remaining == (ADDR_WIDTH+1)'(1))
                           ? HREPLAY_IDLE : HREPLAY_RD;
                end
            end
            default:      w_next = HREPLAY_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_state     <= HREPLAY_IDLE;
            r_head      <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drop  <= (r_state != HREPLAY_IDLE) & i_wen;
            if (w_we) begin
                r_head <= i_waddr + ADDR_WIDTH'(1);
                // count's top bit set means the RAM is full; hold there
                if (!r_count[ADDR_WIDTH]) begin
                    r_count <= r_count + (ADDR_WIDTH+1)'(1);
                end
            end
            if (r_state == HREPLAY_LOAD) begin
                r_rd_ptr    <= r_head - r_count[ADDR_WIDTH-1:0];
                r_remaining <= r_count;
            end
            if (r_state == HREPLAY_RD) begin
                r_valid <= 1'b1;
            end
            if (w_hs) begin
                r_valid     <= 1'b0;
                r_rd_ptr    <= r_rd_ptr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // RAM keeps re-reading rd_ptr during OUT, so data stays stable
    assign o_valid   = r_valid;
    assign o_type    = r_valid ? w_rd[8]   : 1'b0;
    assign o_asciiex = r_valid ? w_rd[7:0] : 8'h00;
    assign o_busy    = (r_state != HREPLAY_IDLE);
    assign o_count   = r_count;
    assign o_drop    = r_drop;
endmodule

// File: tb/tb_history_replayer.sv
// Randomized + directed bench for history_replayer with a queue scoreboard.
module tb_history_replayer;
    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          i_sclr = 1'b1;
    logic          i_wen = 1'b0;
    logic [AW-1:0] i_waddr = '0;
    logic          i_type = 1'b0;
    logic [7:0]    i_asciiex = 8'h00;
    logic          i_replay = 1'b0;
    logic          i_ready = 1'b1;
    logic          o_valid;
    logic          o_type;
    logic [7:0]    o_asciiex;
    logic          o_busy;
    logic [AW:0]   o_count;
    logic          o_drop;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [8:0] m_mem [DEPTH];
    int  m_head = 0;
    int  m_count = 0;
    int  m_left = 0;
    int  m_vwait = 0;
    bit  m_busy = 0;
    bit  m_valid = 0;
    bit  m_drop = 0;
    bit  m_zero = 0;
    logic [8:0] q_exp [$];

    history_replayer #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .i_sclr    (i_sclr),
        .i_wen     (i_wen),
        .i_waddr   (i_waddr),
        .i_type    (i_type),
        .i_asciiex (i_asciiex),
        .i_replay  (i_replay),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_type    (o_type),
        .o_asciiex (o_asciiex),
        .o_busy    (o_busy),
        .o_count   (o_count),
        .o_drop    (o_drop)
    );

    always #5 clk = ~clk;

    // Model: predicts the state after each edge from the inputs it samples.
    initial begin
        forever begin
            @(posedge clk);
            if (i_sclr) begin
                m_busy = 0; m_valid = 0; m_drop = 0;
                m_head = 0; m_count = 0; m_left = 0; m_vwait = 0;
                m_zero = 1;
                q_exp.delete();
            end else begin
                m_zero = 0;
                m_drop = m_busy && i_wen;
                if (!m_busy) begin
                    if (i_wen) begin
                        m_mem[i_waddr] = {i_type, i_asciiex};
                        m_head = (int'(i_waddr) + 1) % DEPTH;
                        if (m_count < DEPTH) m_count++;
                    end
                    if (i_replay) begin
                        m_busy = 1;
                        m_left = m_count;
                        m_vwait = 2;
                        for (int k = 0; k < m_count; k++)
                            q_exp.push_back(
                                m_mem[(m_head - m_count + k + DEPTH) % DEPTH]);
                    end
                end else if (m_valid) begin
                    if (i_ready) begin
                        m_valid = 0;
                        m_left--;
                        if (m_left == 0) m_busy = 0;
                        else m_vwait = 1;
                    end
                end else if (m_left == 0) begin
                    m_busy = 0;
                end else if (m_vwait == 1) begin
                    m_valid = 1;
                end else begin
                    m_vwait--;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    // Monitor: compares outputs mid-cycle, pops the scoreboard on handshakes.
    initial begin
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            chk("o_valid", int'(o_valid), int'(m_valid));
            chk("o_busy", int'(o_busy), int'(m_busy));
            chk("o_count", int'(o_count), m_count);
            chk("o_drop", int'(o_drop), int'(m_drop));
            if (m_zero) begin
                chk("reset_type", int'(o_type), 0);
                chk("reset_asciiex", int'(o_asciiex), 0);
            end
            if (o_valid) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp = q_exp[0];
                    chk("o_entry", int'({o_type, o_asciiex}), int'(exp));
                    if (i_ready && !i_sclr) void'(q_exp.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input bit t, input int c);
        i_wen = 1; i_waddr = AW'(a); i_type = t; i_asciiex = 8'(c);
        step();
        i_wen = 0;
    endtask

    task automatic replay();
        i_replay = 1;
        step();
        i_replay = 0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (o_busy && n < lim) begin
            step();
            n++;
        end
        if (o_busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!o_valid && n < lim) begin
            step();
            n++;
        end
        if (!o_valid) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int widx = 0;
        step(); step();
        i_sclr = 0;
        step();

        // replay of an empty history emits nothing
        replay();
        repeat (10) step();

        // simple in-order replay
        wr(0, 0, 8'h61); wr(1, 0, 8'h62); wr(2, 0, 8'h63);
        i_ready = 1;
        replay();
        wait_idle(40);
        step();

        // backpressure on the first entry
        i_ready = 0;
        replay();
        wait_valid(10);
        repeat (5) step();
        i_ready = 1;
        wait_idle(40);
        step();

        // write during replay is dropped
        replay();
        wr(3, 0, 8'h77);
        step();
        wr(3, 0, 8'h78);
        wait_idle(40);
        step();

        // same-cycle write and replay: new entry comes out last
        i_wen = 1; i_waddr = 2'd3; i_type = 1; i_asciiex = 8'h08;
        i_replay = 1;
        step();
        i_wen = 0; i_replay = 0;
        wait_idle(40);
        step();

        // wrap and saturation
        i_sclr = 1; step(); i_sclr = 0;
        for (int k = 0; k < 6; k++) wr(k % DEPTH, 0, 8'h30 + k);
        replay();
        wait_idle(40);
        step();

        // reset in the middle of output
        i_ready = 0;
        replay();
        wait_valid(10);
        step(); step();
        i_sclr = 1; step(); i_sclr = 0;
        i_ready = 1;
        replay();
        repeat (10) step();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            i_wen     = ($urandom_range(0, 1) == 1);
            i_waddr   = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'(widx);
            i_type    = 1'($urandom);
            i_asciiex = 8'($urandom);
            i_replay  = ($urandom_range(0, 14) == 0);
            i_ready   = ($urandom_range(0, 9) < 7);
            i_sclr    = ($urandom_range(0, 149) == 0);
            step();
            if (i_wen) widx = (int'(i_waddr) + 1) % DEPTH;
        end
        i_wen = 0; i_replay = 0; i_sclr = 0; i_ready = 1;
        wait_idle(100);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
